// File: rtl/lu_pipe_acc.sv
// WIDTH-bit bitwise logic unit with one registered output stage and an accumulator.
// The accumulator can stand in for operand B. Includes a valid/ready handshake and an accepted-transaction counter.
module lu_pipe_acc #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [2:0]       op,
  input  logic             use_acc,
  input  logic             acc_clr,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             ones,
  output logic [WIDTH-1:0] acc,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] opB;
  logic [WIDTH-1:0] trueForm;
  logic [WIDTH-1:0] nextResult;
  logic             accept;
  logic             outFire;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;
  assign outFire  = out_valid && out_ready;

  // op[2:1] picks the function group; op[0]=0 selects the inverted form
  always_comb begin
    opB = use_acc ? acc : b;
    trueForm = '0;
    unique case (op[2:1])
      2'b00: trueForm = a & opB;
      2'b01: trueForm = a | opB;
      2'b10: trueForm = a ^ opB;
      2'b11: trueForm = a;
      default: trueForm = '0;
    endcase
    nextResult = op[0] ? trueForm : ~trueForm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      result    <= '0;
      zero      <= 1'b0;
      ones      <= 1'b0;
      count     <= '0;
    end else if (accept) begin
      out_valid <= 1'b1;
      result    <= nextResult;
      zero      <= (nextResult == '0);
      ones      <= (nextResult == '1);
      count     <= count + CNT_W'(1);
    end else if (outFire) begin
      out_valid <= 1'b0;
    end
  end

  // Clear wins over the accept update, but the operation still saw the old acc
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      acc <= '0;
    else if (acc_clr)
      acc <= '0;
    else if (accept)
      acc <= nextResult;
  end

endmodule

// File: doc/lu_pipe_acc.md
Name: lu_pipe_acc

Overview:
- Parametrised successor of the 1-bit AND/NAND/OR/NOR logic unit: WIDTH-bit bitwise logic unit with eight operations selected by a 3-bit key, one registered output stage and an accumulator register that can replace operand B.
- valid/ready handshake on input and output, so the block can sit between a register-file read stage and a write-back stage in the datapath exercises.
- Carries a transaction counter for bench and debug visibility.

Parameters:
- WIDTH, 8, operand/result/accumulator width in bits (>=1).
- CNT_W, 8, width of the accepted-transaction counter.

Ports:
- clk  input  1  single clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  a/b/op/use_acc valid this cycle.
- in_ready  output  1  block can accept this cycle.
- a  input  WIDTH  operand A.
- b  input  WIDTH  operand B (ignored when use_acc=1).
- op  input  3  operation key (encoding below).
- use_acc  input  1  1: operand B := acc; 0: operand B := b.
- acc_clr  input  1  synchronous clear of acc (independent of handshake).
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts result.
- result  output  WIDTH  registered result.
- zero  output  1  registered: result == 0.
- ones  output  1  registered: result == all ones.
- acc  output  WIDTH  accumulator value.
- count  output  CNT_W  number of accepted inputs, mod 2^CNT_W.

Behaviour:
- Reset (async, active-high): out_valid=0, result=0, zero=0, ones=0, acc=0, count=0. Reset asserted mid-transaction discards the pending result; no output handshake completes. First accept is possible on the first rising edge after deassertion.
- op encoding: op[2:1] selects the group; op[0]=0 inverts, op[0]=1 is true form.
  - 000 NAND, 001 AND, 010 NOR, 011 OR.
  - 100 XNOR, 101 XOR, 110 NOT A, 111 PASS A.
- Operand B = use_acc ? acc (current registered value) : b. All operations are bitwise; no carry, no width growth.
- in_ready = !out_valid || out_ready (combinational; single-entry pipeline with pass-through backpressure).
- Accept: in_valid && in_ready at a rising edge. On accept:
  - result <= f(op, a, B).
  - zero/ones recomputed from the new result.
  - out_valid <= 1.
  - acc <= new result.
  - count <= count+1, wrapping from 2^CNT_W-1 to 0.
- Output handshake: out_valid && out_ready at an edge completes the transfer. If there is no simultaneous accept, out_valid <= 0. If there is a simultaneous accept, out_valid stays 1 and the new result replaces the old one (full throughput, 1 result/cycle).
- While out_valid=1 and out_ready=0:
  - result, zero and ones are held stable.
  - in_ready=0; in_valid is ignored and nothing is consumed.
- Latency: 1 cycle from accept edge to result visible.
- acc_clr: when asserted at an edge, acc <= 0, with priority over the accept update of acc. If accept coincides with acc_clr, the operation still uses the pre-clear acc as B, result/out_valid/count update normally, and acc ends at 0.
- acc_clr does not affect result, out_valid, zero, ones or count.
- Inputs are sampled only on accept; input changes while in_ready=0 have no effect.
- WIDTH=1 must reproduce the original 1-bit LU truth tables for op 000..011.

Test Plan:
- Reset then WIDTH=8, out_ready=1, one-cycle pulses of a=0xF0, b=0x3C, with op=000,001,010,011,100,101,110,111 -> result 0xCF,0x30,0x03,0xFC,0x33,0xCC,0x0F,0xF0 each 1 cycle after accept; count=8; zero=0, ones=0 throughout.
- Accumulate: acc_clr pulse, then a=0x01 op=011 use_acc=1, then a=0x80 op=011 use_acc=1, then a=0xFF op=101 use_acc=1 -> results 0x01, 0x81, 0x7E; acc=0x7E.
- Backpressure: accept a=0xAA,b=0x55,op=011 (result 0xFF, ones=1); hold out_ready=0 for 3 cycles while in_valid=1 with other data -> in_ready=0, result held at 0xFF, count unchanged; raise out_ready -> next input accepted the same cycle, out_valid stays 1.
- Simultaneous acc_clr and accept: acc=0x0F, a=0xFF, op=001, use_acc=1, acc_clr=1 -> result 0x0F, acc=0x00, out_valid=1.
- Count wrap with CNT_W=2: 5 accepts -> count goes 1,2,3,0,1.
- Reset mid-operation: assert reset asynchronously between edges while out_valid=1 -> out_valid, result, acc and count go to 0 immediately without waiting for a clock edge; zero=0.
